// File: rtl/ram8_pkg.sv
// Shared types and sizing for the 8-word register file with handshaked read port.
package ram8_pkg;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        EMPTY,
        FULL
    } rd_state_t;

endpackage : ram8_pkg

// File: rtl/ram8_hs_mux8.sv
// 8:1 combinational word select used for the register-file read path.
module mux8
    import ram8_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  addr_t             sel_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic [WIDTH-1:0]  c_i,
    input  logic [WIDTH-1:0]  d_i,
    input  logic [WIDTH-1:0]  e_i,
    input  logic [WIDTH-1:0]  f_i,
    input  logic [WIDTH-1:0]  g_i,
    input  logic [WIDTH-1:0]  h_i,
    output logic [WIDTH-1:0]  y_o
);

    always_comb begin
        y_o = '0;
        unique case (sel_i)
            3'd0: y_o = a_i;
            3'd1: y_o = b_i;
            3'd2: y_o = c_i;
            3'd3: y_o = d_i;
            3'd4: y_o = e_i;
            3'd5: y_o = f_i;
            3'd6: y_o = g_i;
            3'd7: y_o = h_i;
            default: y_o = '0;
        endcase
    end

endmodule : mux8

// File: rtl/ram8_hs.sv
// 8-word register file: unbuffered write port, 1-cycle valid/ready read port
// with a snapshot output register that holds steady while the consumer stalls.
module ram8_hs
    import ram8_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [2:0]        wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_req_i,
    input  logic [2:0]        rd_addr_i,
    output logic              rd_req_ready_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic [2:0]        rd_addr_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] wr_sel;

    rd_state_t        state_q, state_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    addr_t            rd_addr_q, rd_addr_d;

    logic [WIDTH-1:0] mux_word;
    logic             rd_accept;
    logic             bypass;

    // Write-enable decode: one-hot select of the addressed word.
    always_comb begin
        wr_sel            = '0;
        wr_sel[wr_addr_i] = wr_en_i;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_sel[i]) begin
                mem_d[i] = wr_data_i;
            end
        end
    end

    mux8 #(
        .WIDTH (WIDTH)
    ) u_rd_mux (
        .sel_i (rd_addr_i),
        .a_i   (mem_q[0]),
        .b_i   (mem_q[1]),
        .c_i   (mem_q[2]),
        .d_i   (mem_q[3]),
        .e_i   (mem_q[4]),
        .f_i   (mem_q[5]),
        .g_i   (mem_q[6]),
        .h_i   (mem_q[7]),
        .y_o   (mux_word)
    );

    assign rd_valid_o     = (state_q == FULL);
    assign rd_req_ready_o = !rd_valid_o || rd_ready_i;
    assign rd_accept      = rd_req_i && rd_req_ready_o;

    // Write-first: a same-edge write to the read address is forwarded.
    assign bypass = wr_en_i && (wr_addr_i == rd_addr_i);

    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        rd_addr_d = rd_addr_q;
        unique case (state_q)
            EMPTY: begin
                if (rd_accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (rd_accept) begin
                    state_d = FULL;
                end else if (rd_ready_i) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (rd_accept) begin
            rd_data_d = bypass ? wr_data_i : mux_word;
            rd_addr_d = rd_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            state_q   <= EMPTY;
            rd_data_q <= '0;
            rd_addr_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_addr_o = rd_addr_q;

endmodule : ram8_hs

// File: tb/tb_ram8_hs.sv
// Directed, table-driven bench for ram8_hs plus hand-written stall and reset sequences.
module tb_ram8_hs;

    localparam int unsigned WIDTH = 16;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             wr_en_i;
    logic [2:0]       wr_addr_i;
    logic [WIDTH-1:0] wr_data_i;
    logic             rd_req_i;
    logic [2:0]       rd_addr_i;
    logic             rd_req_ready_o;
    logic             rd_valid_o;
    logic             rd_ready_i;
    logic [WIDTH-1:0] rd_data_o;
    logic [2:0]       rd_addr_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    ram8_hs #(
        .WIDTH (WIDTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .wr_en_i        (wr_en_i),
        .wr_addr_i      (wr_addr_i),
        .wr_data_i      (wr_data_i),
        .rd_req_i       (rd_req_i),
        .rd_addr_i      (rd_addr_i),
        .rd_req_ready_o (rd_req_ready_o),
        .rd_valid_o     (rd_valid_o),
        .rd_ready_i     (rd_ready_i),
        .rd_data_o      (rd_data_o),
        .rd_addr_o      (rd_addr_o)
    );

    typedef struct {
        logic             rst;
        logic             wr_en;
        logic [2:0]       wr_addr;
        logic [WIDTH-1:0] wr_data;
        logic             rd_req;
        logic [2:0]       rd_addr;
        logic             rd_ready;
        logic             exp_rdy;
        logic             exp_valid;
        logic [WIDTH-1:0] exp_data;
        logic [2:0]       exp_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic wr_en, logic [2:0] wr_addr,
                                logic [WIDTH-1:0] wr_data, logic rd_req,
                                logic [2:0] rd_addr, logic rd_ready, logic exp_rdy,
                                logic exp_valid, logic [WIDTH-1:0] exp_data,
                                logic [2:0] exp_addr);
        vec_t v;
        v.rst = rst; v.wr_en = wr_en; v.wr_addr = wr_addr; v.wr_data = wr_data;
        v.rd_req = rd_req; v.rd_addr = rd_addr; v.rd_ready = rd_ready;
        v.exp_rdy = exp_rdy; v.exp_valid = exp_valid;
        v.exp_data = exp_data; v.exp_addr = exp_addr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic wr_en, input logic [2:0] wr_addr,
                         input logic [WIDTH-1:0] wr_data, input logic rd_req,
                         input logic [2:0] rd_addr, input logic rd_ready);
        rst_i = rst; wr_en_i = wr_en; wr_addr_i = wr_addr; wr_data_i = wr_data;
        rd_req_i = rd_req; rd_addr_i = rd_addr; rd_ready_i = rd_ready;
    endtask

    // Inputs are driven 1ns after a rising edge; ready is sampled mid-cycle and
    // the registered outputs 1ns after the following rising edge.
    task automatic step_check(input string tag, input logic exp_rdy, input logic exp_valid,
                              input logic [WIDTH-1:0] exp_data, input logic [2:0] exp_addr);
        #2;
        check({tag, "_rdy"}, 32'(rd_req_ready_o), 32'(exp_rdy));
        @(posedge clk_i);
        #1;
        check({tag, "_valid"}, 32'(rd_valid_o), 32'(exp_valid));
        check({tag, "_data"}, 32'(rd_data_o), 32'(exp_data));
        check({tag, "_addr"}, 32'(rd_addr_o), 32'(exp_addr));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b1, 1'b0, 3'd0, '0, 1'b0, 3'd0, 1'b0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        check("reset_valid", 32'(rd_valid_o), 32'd0);
        check("reset_data", 32'(rd_data_o), 32'd0);
        check("reset_addr", 32'(rd_addr_o), 32'd0);

        // Reads of every address right after reset return zero.
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(0, 0, 0, '0, 1, 3'(k), 1, 1, 1, '0, 3'(k)));
        vecs.push_back(mk(0, 0, 0, '0, 0, 0, 1, 1, 0, '0, 3'd7));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(0, 1, 3'(k), 16'(k * 16'h1111), 0, 0, 0, 1, 0, '0, 3'd7));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(0, 0, 0, '0, 1, 3'(k), 1, 1, 1, 16'(k * 16'h1111), 3'(k)));
        // Same-edge write/read: same address bypasses, different address sees old word.
        vecs.push_back(mk(0, 1, 3'd5, 16'hBEEF, 1, 3'd5, 1, 1, 1, 16'hBEEF, 3'd5));
        vecs.push_back(mk(0, 1, 3'd5, 16'hBEEF, 1, 3'd4, 1, 1, 1, 16'h4444, 3'd4));
        vecs.push_back(mk(0, 0, 0, '0, 0, 0, 1, 1, 0, 16'h4444, 3'd4));
        vecs.push_back(mk(0, 0, 0, '0, 0, 0, 1, 1, 0, 16'h4444, 3'd4));

        drive(1'b0, 1'b0, 3'd0, '0, 1'b0, 3'd0, 1'b0);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data,
                  vecs[i].rd_req, vecs[i].rd_addr, vecs[i].rd_ready);
            step_check($sformatf("v%0d", i), vecs[i].exp_rdy, vecs[i].exp_valid,
                       vecs[i].exp_data, vecs[i].exp_addr);
        end

        // Stall: snapshot holds while the source word is rewritten; pending request waits.
        drive(1'b0, 1'b0, 3'd0, '0, 1'b1, 3'd2, 1'b0);
        step_check("stall_acc", 1'b1, 1'b1, 16'h2222, 3'd2);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b1, 3'd2, 16'hCAFE, 1'b1, 3'd2, 1'b0);
            step_check($sformatf("stall%0d", c), 1'b0, 1'b1, 16'h2222, 3'd2);
        end
        drive(1'b0, 1'b0, 3'd0, '0, 1'b1, 3'd2, 1'b1);
        step_check("stall_rel", 1'b1, 1'b1, 16'hCAFE, 3'd2);

        // Hold a stalled result, then reset with a concurrent write and request.
        drive(1'b0, 1'b0, 3'd0, '0, 1'b0, 3'd0, 1'b0);
        step_check("pre_rst", 1'b0, 1'b1, 16'hCAFE, 3'd2);
        drive(1'b1, 1'b1, 3'd3, 16'h5A5A, 1'b1, 3'd6, 1'b0);
        step_check("rst_mid", 1'b0, 1'b0, '0, 3'd0);
        drive(1'b0, 1'b0, 3'd0, '0, 1'b1, 3'd3, 1'b1);
        step_check("post_rst_rd3", 1'b1, 1'b1, '0, 3'd3);
        drive(1'b0, 1'b0, 3'd0, '0, 1'b1, 3'd5, 1'b1);
        step_check("post_rst_rd5", 1'b1, 1'b1, '0, 3'd5);
        drive(1'b0, 1'b0, 3'd0, '0, 1'b0, 3'd0, 1'b1);
        step_check("drain", 1'b1, 1'b0, '0, 3'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ram8_hs

// File: doc/ram8_hs.md
Name: ram8_hs

Overview:
- 8-word register file with a handshaked read port. Writes are steered into one of eight registers by a 3-bit address; reads select one register through an 8:1 mux into a registered output stage.
- Serves as the storage-plus-read-back building block for the Memory hierarchy (RAM64 and above are built from it).
- Consumers that can stall use the valid/ready read port instead of a bare combinational mux.

Parameters:
- WIDTH, 16, data word width in bits (Hack word).

Ports:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- wr_en_i  in  1  write strobe; writes wr_data_i into word wr_addr_i at the clock edge.
- wr_addr_i  in  3  write address.
- wr_data_i  in  WIDTH  write data.
- rd_req_i  in  1  read request valid.
- rd_addr_i  in  3  read address, sampled when the request is accepted.
- rd_req_ready_o  out  1  read port can accept a request this cycle.
- rd_valid_o  out  1  rd_data_o and rd_addr_o hold a completed read.
- rd_ready_i  in  1  consumer accepts the output this cycle.
- rd_data_o  out  WIDTH  read data.
- rd_addr_o  out  3  address of the word in rd_data_o.

Behaviour:
- Reset (rst_i=1 at an edge):
  - all 8 words become 0;
  - rd_valid_o=0, rd_data_o=0, rd_addr_o=0;
  - takes priority over any concurrent write or read, including a read held mid-handshake.
- Write:
  - mem[wr_addr_i] <= wr_data_i when wr_en_i=1.
  - Only the addressed word changes; the other seven hold.
  - No backpressure on writes.
- Read handshake:
  - rd_req_ready_o = !rd_valid_o || rd_ready_i (combinational).
  - A request is accepted on an edge where rd_req_i && rd_req_ready_o.
  - Latency is 1 cycle: on the cycle after acceptance, rd_valid_o=1 and rd_data_o/rd_addr_o carry the result.
- Output FSM:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept with rd_ready_i=1 (back-to-back, one read per cycle).
  - FULL -> EMPTY on rd_ready_i=1 with no accept.
  - FULL stays FULL with data frozen while rd_ready_i=0.
- Read-during-write, same address, same edge: write-first. The captured data is wr_data_i (bypass), not the old word.
- Read-during-write, different address: the captured data is the unmodified addressed word.
- Stall stability: while rd_valid_o=1 and rd_ready_i=0, rd_data_o/rd_addr_o stay constant, even if the source word is rewritten. The captured value is a snapshot.
- rd_ready_i while rd_valid_o=0 is ignored.
- rd_addr_i is don't-care when rd_req_i=0.
- No X propagation: outputs are always driven. The address space covers all 8 codes, so there is no out-of-range case.

Decomposition:
- Package ram8_pkg: localparam DEPTH=8, ADDR_W=3; typedef logic [ADDR_W-1:0] addr_t; typedef enum logic {EMPTY, FULL} rd_state_t.
- Sub-module mux8 (WIDTH-parameterised, 3-bit sel, eight inputs a..h, one output) implements the combinational read select.
- Write-enable decode and the bypass compare stay inline in ram8_hs.

Test Plan:
- Reset, then read every address 0..7 with rd_ready_i=1 -> rd_valid_o one cycle after each accept; rd_data_o=0 for all; rd_addr_o matches.
- Write 0x1111*k to addr k for k=0..7, then issue 8 back-to-back reads with rd_ready_i=1 -> 8 consecutive valid cycles; data 0x0000,0x1111,...,0x7777; rd_req_ready_o stays 1.
- Same edge: write addr 5 = 0xBEEF and read addr 5 -> rd_data_o=0xBEEF. Repeat with read addr 4 -> old value 0x4444.
- Read addr 2, hold rd_ready_i=0 for 3 cycles while writing addr 2 = 0xCAFE -> rd_data_o stays 0x2222; rd_req_ready_o=0 and a pending rd_req_i is not accepted. Raise rd_ready_i -> stalled request accepted same edge, next data 0xCAFE.
- Assert rst_i while rd_valid_o=1 and stalled, with wr_en_i=1 to addr 3 -> next cycle rd_valid_o=0, rd_data_o=0, and a subsequent read of addr 3 returns 0.
